// File: rtl/vga_pattern_gen.sv
// 640x480 pixel-colour stage: four patterns, RGB and syncs aligned through a 2-stage pipeline.
// Define VGA_PATTERN_BORDER_EN to force a white one-pixel frame around the visible area.
module vga_pattern_gen #(
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480,
  parameter int POS_WIDTH = 12,
  parameter int BOX_SIZE  = 32
) (
  input  logic                 clk_25m,
  input  logic                 reset,
  input  logic [POS_WIDTH-1:0] horizontal_position,
  input  logic [POS_WIDTH-1:0] vertical_position,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic [1:0]           pattern_select,
  output logic [3:0]           vga_r,
  output logic [3:0]           vga_g,
  output logic [3:0]           vga_b,
  output logic                 vga_horizontal_sync,
  output logic                 vga_vertical_sync,
  output logic [7:0]           frame_count
);

  localparam logic [POS_WIDTH-1:0] POS_ZERO = '0;
  localparam logic [POS_WIDTH-1:0] POS_ONE  = POS_WIDTH'(1);
  localparam logic [POS_WIDTH-1:0] H_VIS    = POS_WIDTH'(H_VISIBLE);
  localparam logic [POS_WIDTH-1:0] V_VIS    = POS_WIDTH'(V_VISIBLE);
  localparam logic [POS_WIDTH-1:0] H_LAST   = POS_WIDTH'(H_VISIBLE - 1);
  localparam logic [POS_WIDTH-1:0] V_LAST   = POS_WIDTH'(V_VISIBLE - 1);
  localparam logic [POS_WIDTH-1:0] BAR_LAST = POS_WIDTH'(H_VISIBLE / 8 - 1);
  localparam logic [POS_WIDTH-1:0] BOX_W    = POS_WIDTH'(BOX_SIZE);
  localparam logic [POS_WIDTH-1:0] MAX_X    = POS_WIDTH'(H_VISIBLE - BOX_SIZE);
  localparam logic [POS_WIDTH-1:0] MAX_Y    = POS_WIDTH'(V_VISIBLE - BOX_SIZE);

  // One bounce step for a box axis; returns {dir_neg, pos}.
  function automatic logic [POS_WIDTH:0] axis_step(
    input logic [POS_WIDTH-1:0] pos,
    input logic                 dir_neg,
    input logic [POS_WIDTH-1:0] pos_max
  );
    logic [POS_WIDTH:0] nxt;
    if (!dir_neg && (pos == pos_max)) begin
      nxt = {1'b1, pos_max - POS_ONE};
    end else if (dir_neg && (pos == POS_ZERO)) begin
      nxt = {1'b0, POS_ONE};
    end else if (dir_neg) begin
      nxt = {1'b1, pos - POS_ONE};
    end else begin
      nxt = {1'b0, pos + POS_ONE};
    end
    return nxt;
  endfunction

  logic                 visible_s, fb_s, edge_s, inside_s;
  logic [2:0]           cur_idx_s;
  logic [POS_WIDTH-1:0] cur_col_s;
  logic [POS_WIDTH:0]   box_x_nxt_s, box_y_nxt_s;
  logic [11:0]          pattern_s, rgb_s;

  logic [2:0]           bar_idx_r;
  logic [POS_WIDTH-1:0] bar_col_r;
  logic [1:0]           active_pat_r;
  logic [POS_WIDTH-1:0] box_x_r, box_y_r;
  logic                 dir_x_r, dir_y_r;
  logic [7:0]           frame_cnt_r;
  logic                 vis1_r, hs1_r, vs1_r;
  logic [POS_WIDTH-1:0] h1_r, v1_r;
  logic [2:0]           idx1_r;
  logic [11:0]          rgb_r;
  logic                 hs2_r, vs2_r;

  // Input decode: visibility, frame boundary, bar position for the current column.
  always_comb begin
    visible_s = (horizontal_position < H_VIS) && (vertical_position < V_VIS);
    fb_s      = (vertical_position == V_VIS) && (horizontal_position == POS_ZERO);
    if (horizontal_position == POS_ZERO) begin
      cur_idx_s = 3'd0;
      cur_col_s = POS_ZERO;
    end else begin
      cur_idx_s = bar_idx_r;
      cur_col_s = bar_col_r;
    end
    box_x_nxt_s = axis_step(box_x_r, dir_x_r, MAX_X);
    box_y_nxt_s = axis_step(box_y_r, dir_y_r, MAX_Y);
  end

  // Bar counters hold the index/column expected for the next sequential pixel.
  always_ff @(posedge clk_25m or posedge reset) begin
    if (reset) begin
      bar_idx_r <= 3'd0;
      bar_col_r <= POS_ZERO;
    end else if (cur_col_s == BAR_LAST) begin
      bar_idx_r <= cur_idx_s + 3'd1;
      bar_col_r <= POS_ZERO;
    end else begin
      bar_idx_r <= cur_idx_s;
      bar_col_r <= cur_col_s + POS_ONE;
    end
  end

  // Per-frame state; only touched on the boundary, which lies in blanking.
  always_ff @(posedge clk_25m or posedge reset) begin
    if (reset) begin
      frame_cnt_r  <= 8'd0;
      active_pat_r <= 2'd0;
      box_x_r      <= POS_ZERO;
      box_y_r      <= POS_ZERO;
      dir_x_r      <= 1'b0;
      dir_y_r      <= 1'b0;
    end else if (fb_s) begin
      frame_cnt_r        <= frame_cnt_r + 8'd1;
      active_pat_r       <= pattern_select;
      {dir_x_r, box_x_r} <= box_x_nxt_s;
      {dir_y_r, box_y_r} <= box_y_nxt_s;
    end else begin
      frame_cnt_r  <= frame_cnt_r;
      active_pat_r <= active_pat_r;
    end
  end

  // Pipeline stage 1: capture pixel attributes and syncs.
  always_ff @(posedge clk_25m or posedge reset) begin
    if (reset) begin
      vis1_r <= 1'b0;
      h1_r   <= POS_ZERO;
      v1_r   <= POS_ZERO;
      idx1_r <= 3'd0;
      hs1_r  <= 1'b1;
      vs1_r  <= 1'b1;
    end else begin
      vis1_r <= visible_s;
      h1_r   <= horizontal_position;
      v1_r   <= vertical_position;
      idx1_r <= cur_idx_s;
      hs1_r  <= hsync_in;
      vs1_r  <= vsync_in;
    end
  end

  // Pattern selection and blanking for the stage-1 pixel.
  always_comb begin
    inside_s = (h1_r >= box_x_r) && (h1_r < box_x_r + BOX_W) &&
               (v1_r >= box_y_r) && (v1_r < box_y_r + BOX_W);
    case (active_pat_r)
      2'd0:    pattern_s = {{4{idx1_r[2]}}, {4{idx1_r[1]}}, {4{idx1_r[0]}}};
      2'd1:    pattern_s = (h1_r[5] ^ v1_r[5]) ? 12'hFFF : 12'h000;
      2'd2:    pattern_s = {h1_r[9:6], v1_r[8:5], frame_cnt_r[7:4]};
      2'd3:    pattern_s = inside_s ? 12'hFFF : 12'h004;
      default: pattern_s = 12'h000;
    endcase
`ifdef VGA_PATTERN_BORDER_EN
    edge_s = (h1_r == POS_ZERO) || (h1_r == H_LAST) || (v1_r == POS_ZERO) || (v1_r == V_LAST);
`else
    edge_s = 1'b0;
`endif
    if (!vis1_r) begin
      rgb_s = 12'h000;
    end else if (edge_s) begin
      rgb_s = 12'hFFF;
    end else begin
      rgb_s = pattern_s;
    end
  end

  // Pipeline stage 2: registered pins.
  always_ff @(posedge clk_25m or posedge reset) begin
    if (reset) begin
      rgb_r <= 12'h000;
      hs2_r <= 1'b1;
      vs2_r <= 1'b1;
    end else begin
      rgb_r <= rgb_s;
      hs2_r <= hs1_r;
      vs2_r <= vs1_r;
    end
  end

  assign vga_r               = rgb_r[11:8];
  assign vga_g               = rgb_r[7:4];
  assign vga_b               = rgb_r[3:0];
  assign vga_horizontal_sync = hs2_r;
  assign vga_vertical_sync   = vs2_r;
  assign frame_count         = frame_cnt_r;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomised bench for vga_pattern_gen against a frame-count-based reference model.
module tb_vga_pattern_gen;

  localparam int HV = 640;
  localparam int VV = 480;
  localparam int BOX = 32;
`ifdef VGA_PATTERN_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] hpos, vpos;
  logic        hs_in, vs_in;
  logic [1:0]  sel;
  logic [3:0]  r, g, b;
  logic        hs_out, vs_out;
  logic [7:0]  fc;

  vga_pattern_gen dut (
    .clk_25m(clk), .reset(rst),
    .horizontal_position(hpos), .vertical_position(vpos),
    .hsync_in(hs_in), .vsync_in(vs_in), .pattern_select(sel),
    .vga_r(r), .vga_g(g), .vga_b(b),
    .vga_horizontal_sync(hs_out), .vga_vertical_sync(vs_out),
    .frame_count(fc)
  );

  always #20 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int fb_n, pat, prev_h;
  bit bars_ok, exp_chk, exp_hs, exp_vs;
  int exp_rgb;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Box position after n bounces as a triangle wave of period 2*max.
  function automatic int box_pos(input int n, input int mx);
    int p;
    p = n % (2 * mx);
    return (p <= mx) ? p : 2 * mx - p;
  endfunction

  function automatic int ref_rgb(input int h, input int v);
    int bx, by, idx;
    bx = box_pos(fb_n, HV - BOX);
    by = box_pos(fb_n, VV - BOX);
    if (!(h < HV && v < VV)) return 0;
    if (BORDER && (h == 0 || h == HV - 1 || v == 0 || v == VV - 1)) return 'hFFF;
    case (pat)
      0: begin
        idx = h / (HV / 8);
        return ((idx >> 2) & 1) * 'hF00 + ((idx >> 1) & 1) * 'h0F0 + (idx & 1) * 'h00F;
      end
      1: return ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 'hFFF : 0;
      2: return ((h >> 6) & 15) * 256 + ((v >> 5) & 15) * 16 + ((fb_n % 256) >> 4);
      default: return (h >= bx && h < bx + BOX && v >= by && v < by + BOX) ? 'hFFF : 'h004;
    endcase
  endfunction

  function automatic bit hs_nat(input int h);
    return !(h >= 656 && h < 752);
  endfunction

  function automatic bit vs_nat(input int v);
    return !(v >= 490 && v < 492);
  endfunction

  // Drive one pixel, advance one clock, compare against the pixel driven one step earlier.
  task automatic step(input int h, input int v, input bit hs, input bit vs, input int s);
    int new_rgb;
    bit new_chk;
    hpos = 12'(h); vpos = 12'(v); hs_in = hs; vs_in = vs; sel = 2'(s);
    if (v == VV && h == 0) begin
      fb_n++;
      pat = s;
    end
    if (h == 0) bars_ok = 1'b1;
    else if (h != prev_h + 1) bars_ok = 1'b0;
    prev_h  = h;
    new_rgb = ref_rgb(h, v);
    new_chk = !(pat == 0 && !bars_ok);
    @(posedge clk);
    @(negedge clk);
    check_val("frame_count", int'(fc), fb_n % 256);
    if (exp_chk) check_val("rgb", int'({r, g, b}), exp_rgb);
    check_val("hsync", int'(hs_out), int'(exp_hs));
    check_val("vsync", int'(vs_out), int'(exp_vs));
    exp_rgb = new_rgb; exp_chk = new_chk; exp_hs = hs; exp_vs = vs;
  endtask

  task automatic sweep(input int v, input int s);
    int lows, first;
    lows = 0; first = -1;
    for (int h = 0; h < 800; h++) begin
      step(h, v, hs_nat(h), vs_nat(v), s);
      if (h > 0 && !hs_out) begin
        lows++;
        if (first < 0) first = h;
      end
    end
    check_val("hsync_low_len", lows, 96);
    check_val("hsync_low_start", first, 657);
  endtask

  task automatic fb(input int cnt, input int s);
    for (int i = 0; i < cnt; i++) step(0, VV, 1'b1, 1'b1, s);
  endtask

  task automatic probe(input int h, input int v, input int s, input int exp, input string tag);
    step(h, v, hs_nat(h), vs_nat(v), s);
    step(700, 500, hs_nat(700), vs_nat(500), s);
    check_val(tag, int'({r, g, b}), exp);
  endtask

  task automatic reset_checks(input string tag);
    check_val({tag, "_rgb"}, int'({r, g, b}), 0);
    check_val({tag, "_hs"}, int'(hs_out), 1);
    check_val({tag, "_vs"}, int'(vs_out), 1);
    check_val({tag, "_fc"}, int'(fc), 0);
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1 reset_checks("async_rst");
    fb_n = 0; pat = 0; bars_ok = 1'b0;
    exp_chk = 1'b1; exp_rgb = 0; exp_hs = 1'b1; exp_vs = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks("held_rst");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hpos = '0; vpos = '0; hs_in = 1'b1; vs_in = 1'b1; sel = 2'd0;
    fb_n = 0; pat = 0; prev_h = 0; bars_ok = 1'b0;
    exp_chk = 1'b1; exp_rgb = 0; exp_hs = 1'b1; exp_vs = 1'b1;
    #5 reset_checks("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    sweep(10, 0);
    sweep(VV - 1, 0);

    fb(3, 3);
    probe(3, 3, 3, 'hFFF, "box3_in");
    probe(2, 3, 3, 'h004, "box3_out");
    fb(605, 3);
    probe(608, 288, 3, 'hFFF, "box608_in");
    probe(607, 288, 3, 'h004, "box608_out");
    fb(1, 3);
    probe(607, 287, 3, 'hFFF, "box609_in");
    probe(606, 287, 3, 'h004, "box609_out");

    fb(1, 0);
    sweep(200, 1);
    fb(1, 1);
    probe(32, 0, 1, 'hFFF, "chk_32_0");
    probe(0, 0, 1, BORDER ? 'hFFF : 0, "chk_0_0");
    probe(32, 32, 1, 0, "chk_32_32");

    fb(1, 2);
    probe(0, 100, 2, BORDER ? 'hFFF : ('h030 | ((fb_n % 256) >> 4)), "grad_0_100");
    for (int h = 0; h < 300; h++) step(h, 100, hs_nat(h), vs_nat(100), 2);
    mid_reset();
    for (int h = 300; h < 800; h++) step(h, 100, hs_nat(h), vs_nat(100), 1);
    fb(1, 0);
    check_val("fc_first", int'(fc), 1);
    sweep(50, 0);

    fb(447, 3);
    probe(448, 448, 3, 'hFFF, "boxy448_in");
    probe(448, 447, 3, 'h004, "boxy448_out");
    fb(1, 3);
    probe(449, 447, 3, 'hFFF, "boxy449_in");
    probe(448, 447, 3, 'h004, "boxy449_out");

    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 2))
        0: sweep(int'($urandom_range(0, 524)), int'($urandom_range(0, 3)));
        1: for (int k = 0; k < 300; k++)
             step(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)),
                  1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        default: fb(int'($urandom_range(1, 60)), int'($urandom_range(0, 3)));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
